// File: rtl/inst_rom_resp_pkg.sv
// ============================================================================
// inst_rom_resp_pkg : shared widths, constants, FSM encoding and byte-swap helper
// Revision 1.0
// ============================================================================
`default_nettype none

package inst_rom_resp_pkg;

   localparam int          INST_W    = 32;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // {b0,b1,b2,b3}: turns a little-endian image word into the core's big-endian view
   function automatic logic [INST_W-1:0] bswap32(input logic [INST_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/inst_rom_mem.sv
// ============================================================================
// inst_rom_mem : 2**AW x 32 synchronous 1R1W program store, read-first, no reset
// Revision 1.0
// ============================================================================
`default_nettype none

module inst_rom_mem
   import inst_rom_resp_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic              clk,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [INST_W-1:0] rdata,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [INST_W-1:0] wdata
);

   logic [INST_W-1:0] mem [2**AW];

   // Both updates are non-blocking in one block, so a same-edge write is
   // invisible to the read of that edge.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

endmodule

`default_nettype wire

// File: rtl/inst_rom_resp.sv
// ============================================================================
// inst_rom_resp : wait-state instruction fetch responder with boot-loader write port
// Optional build macro INST_ROM_BSWAP_EN byte-swaps returned words.  Revision 1.0
// ============================================================================
`default_nettype none

module inst_rom_resp
   import inst_rom_resp_pkg::*;
#(
   parameter int          AW          = 10,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rom_ce_i,
   input  logic [31:0]       rom_addr_i,
   output logic [INST_W-1:0] rom_data_o,
   output logic              rom_rdy_o,
   output logic              rom_err_o,
   input  logic              ld_we_i,
   input  logic [AW-1:0]     ld_addr_i,
   input  logic [INST_W-1:0] ld_data_i
);

   localparam logic [3:0] WAIT_INIT    = 4'(WAIT_CYCLES);
   localparam state_t     ACCEPT_STATE = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt;
   logic [31:0]       addr_q;
   logic              err_q;
   logic              accept;
   logic              enter_done;
   logic [31:0]       rd_addr;
   logic [31:0]       offset;
   logic              in_range;
   logic              err_now;
   logic              mem_re;
   logic [INST_W-1:0] mem_q;

   assign accept = rom_ce_i && ((state == ST_IDLE) || (state == ST_DONE));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (rom_ce_i) state_nxt = ACCEPT_STATE;
         ST_WAIT: begin
            if (!rom_ce_i) begin
               state_nxt = ST_IDLE;
            end else if (cnt == 4'd1) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = rom_ce_i ? ACCEPT_STATE : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Zero-wait accepts read straight from the bus; otherwise the latched address is used
   assign enter_done = (state_nxt == ST_DONE);
   assign rd_addr    = accept ? rom_addr_i : addr_q;
   assign offset     = rd_addr - BASE_ADDR;
   assign in_range   = (rd_addr >= BASE_ADDR) && ((offset >> (AW + 2)) == 32'd0);
   assign err_now    = (rd_addr[1:0] != 2'b00) || !in_range;
   assign mem_re     = enter_done && !err_now;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         cnt    <= 4'd0;
         addr_q <= 32'd0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q <= rom_addr_i;
            cnt    <= WAIT_INIT;
         end else if (state == ST_WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_done) begin
            err_q <= err_now;
         end
      end
   end

   inst_rom_mem #(
      .AW (AW)
   ) u_mem (
      .clk   (clk),
      .re    (mem_re),
      .raddr (offset[AW+1:2]),
      .rdata (mem_q),
      .we    (ld_we_i),
      .waddr (ld_addr_i),
      .wdata (ld_data_i)
   );

   assign rom_rdy_o = (state == ST_DONE);
   assign rom_err_o = rom_rdy_o && err_q;

`ifdef INST_ROM_BSWAP_EN
   assign rom_data_o = (rom_rdy_o && !err_q) ? bswap32(mem_q) : ZERO_WORD;
`else
   assign rom_data_o = (rom_rdy_o && !err_q) ? mem_q : ZERO_WORD;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_resp.sv
// ============================================================================
// tb_inst_rom_resp : scoreboard + vector-table bench for three wait-state builds
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_inst_rom_resp;

   localparam int WAITS [3] = '{0, 1, 3};

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] d;
      logic        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic [31:0] addr = 32'd0;
   logic        ld_we = 1'b0;
   logic [9:0]  ld_addr = 10'd0;
   logic [31:0] ld_data = 32'd0;
   logic [31:0] data [3];
   logic        rdy [3];
   logic        err [3];

   int          n_vec = 0;
   int          n_err = 0;
   int          sel = 0;
   logic        mon_on = 1'b0;
   exp_t        sb [$];
   logic [31:0] model [1024];
   vec_t        vt [8];

   always #5 clk = ~clk;

   inst_rom_resp #(.AW(10), .WAIT_CYCLES(WAITS[0]), .BASE_ADDR(32'h0)) u_w0 (
      .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr),
      .rom_data_o(data[0]), .rom_rdy_o(rdy[0]), .rom_err_o(err[0]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

   inst_rom_resp #(.AW(10), .WAIT_CYCLES(WAITS[1]), .BASE_ADDR(32'h0)) u_w1 (
      .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr),
      .rom_data_o(data[1]), .rom_rdy_o(rdy[1]), .rom_err_o(err[1]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

   inst_rom_resp #(.AW(10), .WAIT_CYCLES(WAITS[2]), .BASE_ADDR(32'h0)) u_w3 (
      .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr),
      .rom_data_o(data[2]), .rom_rdy_o(rdy[2]), .rom_err_o(err[2]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef INST_ROM_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   // Scoreboard: every ready strobe of the selected build must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (mon_on && rdy[sel]) begin
         if (sb.size() == 0) begin
            check("spurious_rdy", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("rdy_data", data[sel], e.d);
            check("rdy_err", {31'd0, err[sel]}, {31'd0, e.e});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [31:0] d);
      ld_we   = 1'b1;
      ld_addr = 10'(a);
      ld_data = d;
      cyc();
      ld_we      = 1'b0;
      model[a]   = d;
   endtask

   task automatic request(input int inst, input logic [31:0] a,
                          input logic [31:0] ed, input logic ee);
      int lat;
      sel  = inst;
      sb.push_back('{d: ed, e: ee});
      ce   = 1'b1;
      addr = a;
      lat  = 0;
      do begin
         cyc();
         lat++;
      end while (!rdy[inst] && lat < 20);
      check("latency", 32'(lat), 32'(WAITS[inst] + 1));
      ce = 1'b0;
   endtask

   task automatic drain_check(input string name);
      ce = 1'b0;
      repeat (6) cyc();
      check(name, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int lat;

      // Reset held with a request pending: everything stays quiet
      ce   = 1'b1;
      addr = 32'h0;
      repeat (4) begin
         cyc();
         for (int i = 0; i < 3; i++) begin
            check("reset_rdy", {31'd0, rdy[i]}, 32'd0);
            check("reset_data", data[i], 32'd0);
            check("reset_err", {31'd0, err[i]}, 32'd0);
         end
      end
      ce  = 1'b0;
      rst = 1'b1;
      repeat (3) begin
         cyc();
         for (int i = 0; i < 3; i++) check("post_reset_rdy", {31'd0, rdy[i]}, 32'd0);
      end

      mon_on = 1'b1;
      for (int i = 0; i < 8; i++) load(i, 32'h1000_0000 + 32'(i) * 32'h0101_0101);
      load(3, 32'h3401_0011);
      load(1023, 32'hCAFE_F00D);

      // Single fetch through one wait state
      request(1, 32'h0000_000C, exp_word(32'h3401_0011), 1'b0);
      drain_check("t2_drain");

      vt[0] = '{addr: 32'h0000_0000, d: exp_word(model[0]),    e: 1'b0};
      vt[1] = '{addr: 32'h0000_0004, d: exp_word(model[1]),    e: 1'b0};
      vt[2] = '{addr: 32'h0000_0008, d: exp_word(model[2]),    e: 1'b0};
      vt[3] = '{addr: 32'h0000_0002, d: 32'h0,                 e: 1'b1};
      vt[4] = '{addr: 32'h0000_1000, d: 32'h0,                 e: 1'b1};
      vt[5] = '{addr: 32'h0000_000C, d: exp_word(model[3]),    e: 1'b0};
      vt[6] = '{addr: 32'h0000_0FFC, d: exp_word(model[1023]), e: 1'b0};
      vt[7] = '{addr: 32'hFFFF_FFFC, d: 32'h0,                 e: 1'b1};

      // Zero-wait build streaming back-to-back with enable held high
      sel = 0;
      ce  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         addr = vt[i].addr;
         sb.push_back('{d: vt[i].d, e: vt[i].e});
         cyc();
         check("stream_rdy", {31'd0, rdy[0]}, 32'd1);
      end
      drain_check("t3_drain");

      request(1, 32'h0000_0002, 32'h0, 1'b1);
      request(1, 32'h0000_1000, 32'h0, 1'b1);
      drain_check("t4_drain");

      // Enable dropped mid-wait: abort with no strobe, then full latency
      sel  = 2;
      ce   = 1'b1;
      addr = 32'h0000_0010;
      cyc();
      cyc();
      ce = 1'b0;
      repeat (6) begin
         cyc();
         check("abort_rdy", {31'd0, rdy[2]}, 32'd0);
         check("abort_data", data[2], 32'd0);
      end
      request(2, 32'h0000_0010, exp_word(model[4]), 1'b0);
      drain_check("t5a_drain");

      // Address bus change during the wait is ignored
      sb.push_back('{d: exp_word(model[5]), e: 1'b0});
      ce   = 1'b1;
      addr = 32'h0000_0014;
      cyc();
      addr = 32'h0000_0000;
      lat  = 1;
      while (!rdy[2] && lat < 20) begin
         cyc();
         lat++;
      end
      check("latched_addr_latency", 32'(lat), 32'd4);
      drain_check("t5b_drain");

      // Loader write on the read edge returns the old word, later reads see the new one
      sel = 1;
      sb.push_back('{d: exp_word(model[5]), e: 1'b0});
      ce   = 1'b1;
      addr = 32'h0000_0014;
      cyc();
      ld_we   = 1'b1;
      ld_addr = 10'd5;
      ld_data = 32'hDEAD_BEEF;
      cyc();
      ld_we = 1'b0;
      check("rf_rdy", {31'd0, rdy[1]}, 32'd1);
      model[5] = 32'hDEAD_BEEF;
      drain_check("t6a_drain");
      request(1, 32'h0000_0014, exp_word(32'hDEAD_BEEF), 1'b0);
      drain_check("t6b_drain");

      // Asynchronous reset while a strobe is up clears outputs without a clock edge
      mon_on = 1'b0;
      ce     = 1'b1;
      addr   = 32'h0000_0000;
      cyc();
      cyc();
      check("pre_arst_rdy", {31'd0, rdy[1]}, 32'd1);
      ce = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_rdy", {31'd0, rdy[1]}, 32'd0);
      check("arst_data", data[1], 32'd0);
      check("arst_err", {31'd0, err[1]}, 32'd0);
      #2 rst = 1'b1;

      // Reset mid-wait aborts the request for good
      mon_on = 1'b1;
      sel    = 2;
      ce     = 1'b1;
      addr   = 32'h0000_0004;
      cyc();
      cyc();
      #2 rst = 1'b0;
      ce = 1'b0;
      #1;
      check("arst_wait_rdy", {31'd0, rdy[2]}, 32'd0);
      cyc();
      rst = 1'b1;
      repeat (6) begin
         cyc();
         for (int i = 0; i < 3; i++) check("post_arst_rdy", {31'd0, rdy[i]}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
